bj_ram_sequencer: RTL and testbench
===================================

BJ_RAM_SEQUENCER -- requirements
Module: bj_ram_sequencer

Interface
REQ-001 Parameter CURRENCY_BITS, default 16, SHALL set the width of the balance, bet and RAM data path.
REQ-002 Parameter MAX_CARDS, default 6, SHALL set the card slots per hand; 4+2*MAX_CARDS<=16 required.
REQ-003 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 req_valid  in  1  command request.
REQ-006 req_ready  out  1  high only in IDLE; a command is accepted when req_valid&&req_ready.
REQ-007 req_op  in  2  0 PLACE_BET, 1 DEAL_PLAYER, 2 DEAL_DEALER, 3 SETTLE.
REQ-008 req_operand  in  CURRENCY_BITS  bet amount, card code in [3:0], or outcome in [1:0] (0 lose, 1 push, 2 win, 3 blackjack).
REQ-009 done  out  1  one-cycle pulse at command completion.
REQ-010 err  out  1  valid with done; 1 means rejected and no RAM write occurred.
REQ-011 ram_addr  out  4; ram_wdata  out  CURRENCY_BITS; ram_we  out  1  RAM master port.
REQ-012 ram_rdata  in  CURRENCY_BITS  registered read data, valid one cycle after ram_addr is presented.

Function
REQ-013 Memory map SHALL be: 0 balance, 1 bet, 2 player count, 3 dealer count, 4.. player cards, 4+MAX_CARDS.. dealer cards.
REQ-014 FSM states SHALL be IDLE, RD_ISSUE, RD_CAPTURE, WRITE, DONE; op and operand are latched on acceptance.
REQ-015 Each read SHALL be RD_ISSUE (addr driven, we=0), then RD_CAPTURE (ram_rdata latched); reads are strictly sequential.
REQ-016 WRITE SHALL issue one ram_we=1 cycle per listed write, in listed order, then enter DONE; DONE pulses done and returns to IDLE.
REQ-017 PLACE_BET: read balance; err if operand==0 or operand>balance; else write balance-operand to addr 0, then operand to addr 1.
REQ-018 DEAL_x: read the relevant count; err if count>=MAX_CARDS; else write card (zero-extended [3:0]) to start+count, then count+1 to the count address.
REQ-019 SETTLE: read bet, then balance; payout SHALL be 0/bet/2*bet/bet*2+(bet>>1) for lose/push/win/blackjack.
REQ-020 SETTLE writes, in order: balance+payout to 0, 0 to 1, 0 to 2, 0 to 3; never errs.
REQ-021 Payout and balance sums SHALL be computed CURRENCY_BITS+2 wide before width reduction (see REQ-025).
REQ-022 ram_we SHALL be 0 in every state except WRITE; ram_addr/ram_wdata are don't-care when idle but held at 0.
REQ-023 req_valid while busy SHALL be ignored (not queued); err path goes RD_CAPTURE -> DONE with err=1, no writes.

Reset
REQ-024 On rst: state IDLE, req_ready=1, done=0, err=0, ram_we=0, ram_addr=0, ram_wdata=0; rst mid-command aborts it immediately, with no further writes and no done.

Configuration
REQ-025 With BJ_SEQ_SAT_EN defined, a new balance exceeding 2^CURRENCY_BITS-1 SHALL saturate to all-ones; without it, the balance SHALL wrap modulo 2^CURRENCY_BITS.

Structure
REQ-026 Package bj_ram_pkg SHALL hold the address constants, the op encoding and the outcome encoding, shared with the RAM.
REQ-027 Payout arithmetic SHALL be isolated in combinational sub-module bj_payout_calc (bet, outcome -> wide payout).

Verification
REQ-028 Bench SHALL model the RAM with 1-cycle read latency and a post-reset balance of 1000.
REQ-029 PLACE_BET 100 -> writes 900 to addr 0 and 100 to addr 1; done with err=0; total 5 cycles accept-to-done.
REQ-030 PLACE_BET 1001 with balance 1000 -> done with err=1; no ram_we pulse.
REQ-031 Seven DEAL_PLAYER with cards 1..7 -> the first six write addr 4..9 and counts 1..6; the seventh errs.
REQ-032 Bet 100, SETTLE blackjack -> balance 900+250=1150; bet and both counts are 0.
REQ-033 Balance 65500, bet 100, SETTLE win: with BJ_SEQ_SAT_EN -> 65535; without it -> 164 (65700 mod 65536).
REQ-034 rst asserted during the WRITE of a DEAL -> no further writes, no done, req_ready=1 the cycle after reset.

Source files
------------

// File: rtl/bj_ram_pkg.sv
// Shared constants for the blackjack RAM sequencer and the table RAM:
// memory map, command op encoding and hand outcome encoding.
package bj_ram_pkg;

    // Fixed part of the memory map; card slots follow from ADDR_PCARDS.
    localparam logic [3:0] ADDR_BALANCE = 4'd0;
    localparam logic [3:0] ADDR_BET     = 4'd1;
    localparam logic [3:0] ADDR_PCOUNT  = 4'd2;
    localparam logic [3:0] ADDR_DCOUNT  = 4'd3;
    localparam logic [3:0] ADDR_PCARDS  = 4'd4;

    // Command encoding on req_op.
    localparam logic [1:0] OP_PLACE_BET   = 2'd0;
    localparam logic [1:0] OP_DEAL_PLAYER = 2'd1;
    localparam logic [1:0] OP_DEAL_DEALER = 2'd2;
    localparam logic [1:0] OP_SETTLE      = 2'd3;

    // Outcome encoding in req_operand[1:0] for SETTLE.
    localparam logic [1:0] OUT_LOSE      = 2'd0;
    localparam logic [1:0] OUT_PUSH      = 2'd1;
    localparam logic [1:0] OUT_WIN       = 2'd2;
    localparam logic [1:0] OUT_BLACKJACK = 2'd3;

    // Dealer card slots start right after the player's slots.
    function automatic logic [3:0] dealer_base(input int unsigned max_cards);
        return 4'(32'(ADDR_PCARDS) + max_cards);
    endfunction

endpackage

// File: rtl/bj_payout_calc.sv
// Combinational payout for a settled hand: 0, bet, 2*bet or 2*bet+bet/2.
// Result is two bits wider than the bet so blackjack never overflows.
module bj_payout_calc
    import bj_ram_pkg::*;
#(
    parameter int CURRENCY_BITS = 16
) (
    input  logic [CURRENCY_BITS-1:0] bet,
    input  logic [1:0]               outcome,
    output logic [CURRENCY_BITS+1:0] payout
);

    logic [CURRENCY_BITS+1:0] bet_w;

    // Select the payout multiple for the outcome.
    always_comb begin
        bet_w  = {2'b00, bet};
        payout = '0;
        case (outcome)
            OUT_LOSE:      payout = '0;
            OUT_PUSH:      payout = bet_w;
            OUT_WIN:       payout = bet_w << 1;
            OUT_BLACKJACK: payout = (bet_w << 1) + (bet_w >> 1);
            default:       payout = '0;
        endcase
    end

endmodule

// File: rtl/bj_ram_sequencer.sv
// Blackjack table sequencer driving a single-port RAM with registered reads.
// Each command does one or two reads, decides accept/reject, then issues its
// writes one per cycle. Define BJ_SEQ_SAT_EN to saturate the settled balance
// instead of letting it wrap.
module bj_ram_sequencer
    import bj_ram_pkg::*;
#(
    parameter int CURRENCY_BITS = 16,
    parameter int MAX_CARDS     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [CURRENCY_BITS-1:0] req_operand,
    output logic                     done,
    output logic                     err,
    output logic [3:0]               ram_addr,
    output logic [CURRENCY_BITS-1:0] ram_wdata,
    output logic                     ram_we,
    input  logic [CURRENCY_BITS-1:0] ram_rdata
);

    localparam int W = CURRENCY_BITS;
    localparam logic [3:0] DEALER_BASE = dealer_base(MAX_CARDS);

`ifdef BJ_SEQ_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_RD_ISSUE   = 3'd1;
    localparam logic [2:0] S_RD_CAPTURE = 3'd2;
    localparam logic [2:0] S_WRITE      = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    logic [2:0]   state;
    logic [1:0]   op_q;
    logic [W-1:0] operand_q;
    logic         rd_idx;
    logic [1:0]   wr_idx;
    logic [W-1:0] val_a;      // balance (bet), count (deal), bet (settle)
    logic [W-1:0] val_b;      // balance (settle)
    logic         err_q;

    logic [3:0]   rd_addr;
    logic         last_rd;
    logic         reject;
    logic         wr_last;
    logic [3:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic [W+1:0] payout;
    logic [W+1:0] balance_sum;
    logic [W-1:0] new_balance;

    bj_payout_calc #(.CURRENCY_BITS(W)) u_payout (
        .bet     (val_a),
        .outcome (operand_q[1:0]),
        .payout  (payout)
    );

    // Read address, accept/reject decision on the final read, settled balance.
    always_comb begin
        rd_addr = ADDR_BALANCE;
        reject  = 1'b0;
        case (op_q)
            OP_PLACE_BET: begin
                rd_addr = ADDR_BALANCE;
                reject  = (operand_q == '0) || (operand_q > ram_rdata);
            end
            OP_DEAL_PLAYER: begin
                rd_addr = ADDR_PCOUNT;
                reject  = ram_rdata >= W'(MAX_CARDS);
            end
            OP_DEAL_DEALER: begin
                rd_addr = ADDR_DCOUNT;
                reject  = ram_rdata >= W'(MAX_CARDS);
            end
            default: begin
                rd_addr = rd_idx ? ADDR_BALANCE : ADDR_BET;
                reject  = 1'b0;
            end
        endcase
        last_rd     = (op_q != OP_SETTLE) || rd_idx;
        wr_last     = (op_q == OP_SETTLE) ? (wr_idx == 2'd3) : (wr_idx == 2'd1);
        balance_sum = {2'b00, val_b} + payout;
        new_balance = (SAT_EN && (|balance_sum[W+1:W])) ? '1 : balance_sum[W-1:0];
    end

    // Address/data of the current write slot, in command-specific order.
    always_comb begin
        wr_addr = ADDR_BALANCE;
        wr_data = '0;
        case (op_q)
            OP_PLACE_BET: begin
                wr_addr = wr_idx[0] ? ADDR_BET : ADDR_BALANCE;
                wr_data = wr_idx[0] ? operand_q : (val_a - operand_q);
            end
            OP_DEAL_PLAYER, OP_DEAL_DEALER: begin
                if (wr_idx[0]) begin
                    wr_addr = (op_q == OP_DEAL_PLAYER) ? ADDR_PCOUNT : ADDR_DCOUNT;
                    wr_data = val_a + W'(1);
                end else begin
                    wr_addr = ((op_q == OP_DEAL_PLAYER) ? ADDR_PCARDS : DEALER_BASE) + val_a[3:0];
                    wr_data = {{(W-4){1'b0}}, operand_q[3:0]};
                end
            end
            default: begin
                wr_addr = {2'b00, wr_idx};
                wr_data = (wr_idx == 2'd0) ? new_balance : '0;
            end
        endcase
    end

    // RAM port and handshake outputs decoded from the state.
    always_comb begin
        req_ready = (state == S_IDLE);
        done      = (state == S_DONE);
        err       = (state == S_DONE) && err_q;
        ram_we    = (state == S_WRITE) && !rst;   // reset cancels a write in flight
        ram_addr  = (state == S_RD_ISSUE) ? rd_addr :
                    (state == S_WRITE)    ? wr_addr : 4'd0;
        ram_wdata = (state == S_WRITE) ? wr_data : '0;
    end

    // Command sequencing: accept, read(s), write(s), completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            operand_q <= '0;
            rd_idx    <= 1'b0;
            wr_idx    <= '0;
            val_a     <= '0;
            val_b     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        operand_q <= req_operand;
                        rd_idx    <= 1'b0;
                        wr_idx    <= '0;
                        err_q     <= 1'b0;
                        state     <= S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: state <= S_RD_CAPTURE;
                S_RD_CAPTURE: begin
                    if (rd_idx) val_b <= ram_rdata;
                    else        val_a <= ram_rdata;
                    if (!last_rd) begin
                        rd_idx <= 1'b1;
                        state  <= S_RD_ISSUE;
                    end else if (reject) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_last) state <= S_DONE;
                    else         wr_idx <= wr_idx + 2'd1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bj_ram_sequencer.sv
// Scoreboard bench for bj_ram_sequencer: directed commands push expected RAM
// writes and completions; a negedge monitor pops and compares them.
module tb_bj_ram_sequencer;

    localparam int W    = 16;
    localparam int MAXC = 6;

`ifdef BJ_SEQ_SAT_EN
    localparam logic [W-1:0] OVF_BAL = 16'd65535;
`else
    localparam logic [W-1:0] OVF_BAL = 16'd164;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'd0;
    logic [W-1:0] req_operand = '0;
    logic         done;
    logic         err;
    logic [3:0]   ram_addr;
    logic [W-1:0] ram_wdata;
    logic         ram_we;
    logic [W-1:0] ram_rdata;

    always #5 clk = ~clk;

    bj_ram_sequencer #(.CURRENCY_BITS(W), .MAX_CARDS(MAXC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_operand (req_operand),
        .done        (done),
        .err         (err),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata)
    );

    // RAM model: registered read, balance 1000 after reset, preload port.
    logic [W-1:0] mem [16];
    logic         pre_en = 1'b0;
    logic [3:0]   pre_addr = 4'd0;
    logic [W-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[0]    <= 16'd1000;
            ram_rdata <= '0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            if (pre_en) mem[pre_addr] <= pre_data;
            ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct { logic [3:0] addr; logic [W-1:0] data; } wr_t;
    typedef struct { logic err; int lat; } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  accept_cyc = 0;
    int  done_seen = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Monitor: compare every write and completion against the scoreboard.
    initial begin
        wr_t w;
        dn_t d;
        forever begin
            @(negedge clk);
            cyc++;
            if (req_valid && req_ready) accept_cyc = cyc;
            if (ram_we === 1'b1) begin
                if (wq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write addr=%0d data=%0d", ram_addr, ram_wdata);
                end else begin
                    w = wq.pop_front();
                    chk("write_addr", 32'(ram_addr), 32'(w.addr));
                    chk("write_data", 32'(ram_wdata), 32'(w.data));
                end
            end
            if (done === 1'b1) begin
                done_seen++;
                if (dq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done err=%0d", err);
                end else begin
                    d = dq.pop_front();
                    chk("done_err", 32'(err), 32'(d.err));
                    chk("done_latency", 32'(cyc - accept_cyc), 32'(d.lat));
                end
            end
        end
    end

    task automatic exp_wr(input logic [3:0] a, input logic [W-1:0] v);
        wr_t w;
        w.addr = a;
        w.data = v;
        wq.push_back(w);
    endtask

    task automatic preload(input logic [3:0] a, input logic [W-1:0] v);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_data = v;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [W-1:0] operand,
                       input logic exp_err, input int lat, input bit hold_busy);
        dn_t d;
        bit  ok;
        int  start;
        d.err = exp_err;
        d.lat = lat;
        dq.push_back(d);
        start = done_seen;
        @(posedge clk); #1;
        req_op = op; req_operand = operand; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        if (hold_busy) begin
            req_operand = operand ^ 16'h00FF;
            repeat (3) @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL accept_timeout op=%0d got=not_ready exp=ready", op);
        end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (done_seen != start) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL done_timeout op=%0d got=no_done exp=done", op);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        rst = 1'b0;

        // Rejected bets: too large, zero.
        cmd(2'd0, 16'd1001, 1'b1, 3, 1'b0);
        cmd(2'd0, 16'd0, 1'b1, 3, 1'b0);
        // Good bet, with req_valid held while busy (must be ignored).
        exp_wr(4'd0, 16'd900); exp_wr(4'd1, 16'd100);
        cmd(2'd0, 16'd100, 1'b0, 5, 1'b1);

        // Player cards 1..6 fill slots 4..9; seventh is rejected.
        for (int i = 0; i < 6; i++) begin
            exp_wr(4'(4 + i), W'(i + 1));
            exp_wr(4'd2, W'(i + 1));
            cmd(2'd1, W'(i + 1), 1'b0, 5, 1'b0);
        end
        cmd(2'd1, 16'd7, 1'b1, 3, 1'b0);

        // One dealer card to slot 10.
        exp_wr(4'd10, 16'd9); exp_wr(4'd3, 16'd1);
        cmd(2'd2, 16'd9, 1'b0, 5, 1'b0);

        // Blackjack on bet 100: 900 + 250.
        exp_wr(4'd0, 16'd1150); exp_wr(4'd1, 16'd0); exp_wr(4'd2, 16'd0); exp_wr(4'd3, 16'd0);
        cmd(2'd3, 16'd3, 1'b0, 9, 1'b0);
        chk("mem_balance_bj", 32'(mem[0]), 32'd1150);
        chk("mem_pcount_bj", 32'(mem[2]), 32'd0);

        // Win overflowing the balance: 65500 + 200.
        preload(4'd0, 16'd65500); preload(4'd1, 16'd100);
        exp_wr(4'd0, OVF_BAL); exp_wr(4'd1, 16'd0); exp_wr(4'd2, 16'd0); exp_wr(4'd3, 16'd0);
        cmd(2'd3, 16'd2, 1'b0, 9, 1'b0);

        // Push, lose, and blackjack on an odd bet (41 -> 102).
        preload(4'd0, 16'd500); preload(4'd1, 16'd40);
        exp_wr(4'd0, 16'd540); exp_wr(4'd1, 16'd0); exp_wr(4'd2, 16'd0); exp_wr(4'd3, 16'd0);
        cmd(2'd3, 16'd1, 1'b0, 9, 1'b0);
        preload(4'd1, 16'd40);
        exp_wr(4'd0, 16'd540); exp_wr(4'd1, 16'd0); exp_wr(4'd2, 16'd0); exp_wr(4'd3, 16'd0);
        cmd(2'd3, 16'd0, 1'b0, 9, 1'b0);
        preload(4'd0, 16'd1000); preload(4'd1, 16'd41);
        exp_wr(4'd0, 16'd1102); exp_wr(4'd1, 16'd0); exp_wr(4'd2, 16'd0); exp_wr(4'd3, 16'd0);
        cmd(2'd3, 16'd3, 1'b0, 9, 1'b0);

        // Last dealer slot (count 5 -> addr 15), card taken from operand[3:0]; then full.
        preload(4'd3, 16'd5);
        exp_wr(4'd15, 16'd13); exp_wr(4'd3, 16'd6);
        cmd(2'd2, 16'hABCD, 1'b0, 5, 1'b0);
        cmd(2'd2, 16'd2, 1'b1, 3, 1'b0);

        // Reset during the first write of a deal: only that write lands, no done.
        exp_wr(4'd4, 16'd5);
        @(posedge clk); #1;
        req_op = 2'd1; req_operand = 16'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ram_we === 1'b1) begin seen = 1'b1; break; end
        end
        chk("reset_test_write_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_ram_we", 32'(ram_we), 32'd0);
        repeat (8) @(posedge clk);

        chk("writes_outstanding", 32'(wq.size()), 32'd0);
        chk("dones_outstanding", 32'(dq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
